// File: rtl/fxyzw_scan.sv
// Truth-table scanner: walks {x,y,w,z} through 0..15, samples s_in after SETTLE_CYCLES, builds a 16-bit map.
// Optional mismatch counter on err_cnt is compiled in when FXYZW_SCAN_ERRCNT_EN is defined.
module fxyzw_scan #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        s_in,
    output logic        x,
    output logic        y,
    output logic        w,
    output logic        z,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        match,
    output logic [4:0]  err_cnt
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_range
        $error("fxyzw_scan: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] expected_q, expected_d;
    logic [15:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        match_q, match_d;
`ifdef FXYZW_SCAN_ERRCNT_EN
    logic [4:0]  err_cnt_q, err_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        expected_d = expected_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = done_q;
        match_d    = match_q;
`ifdef FXYZW_SCAN_ERRCNT_EN
        err_cnt_d  = err_cnt_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    expected_d = expected;
                    idx_d      = 4'd0;
                    cnt_d      = 4'd0;
                    result_d   = 16'd0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    match_d    = 1'b0;
`ifdef FXYZW_SCAN_ERRCNT_EN
                    err_cnt_d  = 5'd0;
`endif
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                result_d[idx_q] = s_in;
`ifdef FXYZW_SCAN_ERRCNT_EN
                if (s_in != expected_q[idx_q]) begin
                    err_cnt_d = err_cnt_q + 5'd1;
                end
`endif
                if (idx_q == 4'd15) begin
                    // idx stays at 15 so the function under test sees 1,1,1,1 while done.
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    match_d = (result_d == expected_q);
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = 4'd0;
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            cnt_q      <= 4'd0;
            expected_q <= 16'd0;
            result_q   <= 16'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            match_q    <= 1'b0;
`ifdef FXYZW_SCAN_ERRCNT_EN
            err_cnt_q  <= 5'd0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            expected_q <= expected_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            match_q    <= match_d;
`ifdef FXYZW_SCAN_ERRCNT_EN
            err_cnt_q  <= err_cnt_d;
`endif
        end
    end

    assign {x, y, w, z} = idx_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign match  = match_q;
`ifdef FXYZW_SCAN_ERRCNT_EN
    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 5'd0;
`endif

endmodule

// File: tb/tb_fxyzw_scan.sv
// Bench for fxyzw_scan: table vectors, random function maps and hand-written corner sequences.
module tb_fxyzw_scan;

`ifdef FXYZW_SCAN_ERRCNT_EN
    localparam bit ERRCNT_ON = 1'b1;
`else
    localparam bit ERRCNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start1, start3, s_in1, s_in3;
    logic [15:0] expected1, expected3, result1, result3, func_map;
    logic        x1, y1, w1, z1, busy1, done1, match1;
    logic        x3, y3, w3, z3, busy3, done3, match3;
    logic [4:0]  err1, err3;

    int n_checks = 0;
    int n_err    = 0;

    // Function under test for the default instance: a lookup into func_map.
    assign s_in1 = func_map[{x1, y1, w1, z1}];
    // Slow instance sees x^z through one register stage.
    always_ff @(posedge clk) s_in3 <= x3 ^ z3;

    fxyzw_scan #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .expected(expected1), .s_in(s_in1),
        .x(x1), .y(y1), .w(w1), .z(z1), .busy(busy1), .done(done1),
        .result(result1), .match(match1), .err_cnt(err1)
    );

    fxyzw_scan #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .expected(expected3), .s_in(s_in3),
        .x(x3), .y(y3), .w(w3), .z(z3), .busy(busy3), .done(done3),
        .result(result3), .match(match3), .err_cnt(err3)
    );

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Runs one scan on dut1; optionally pulses start again when the vector index equals poke_idx.
    task automatic do_scan1(input string tag, input logic [15:0] fmap, input logic [15:0] ex,
                            input int poke_idx, input logic [15:0] want_res,
                            input logic want_mat, input logic [4:0] want_err);
        int lat;
        bit poked;
        func_map  = fmap;
        expected1 = ex;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0; expected1 = ~ex;
        chk({tag, "_busy_rise"}, int'(busy1), 1);
        chk({tag, "_match_clr"}, int'(match1), 0);
        lat   = 0;
        poked = 1'b0;
        while (!done1 && lat < 200) begin
            if (poke_idx >= 0 && !poked && int'({x1, y1, w1, z1}) == poke_idx) begin
                start1 = 1'b1;
                poked  = 1'b1;
            end
            @(negedge clk);
            start1 = 1'b0;
            lat++;
        end
        chk({tag, "_latency"}, lat, 32);
        chk({tag, "_result"},  int'(result1), int'(want_res));
        chk({tag, "_match"},   int'(match1), int'(want_mat));
        chk({tag, "_err_cnt"}, int'(err1), int'(want_err));
        chk({tag, "_busy_fall"}, int'(busy1), 0);
        chk({tag, "_xywz_hold"}, int'({x1, y1, w1, z1}), 15);
        $display("scan %s: fmap=%h exp=%h result=%h match=%b err_cnt=%0d cycles=%0d",
                 tag, fmap, ex, result1, match1, err1, lat);
    endtask

    typedef struct {
        logic [15:0] fmap;
        logic [15:0] exp_in;
        logic [15:0] res;
        logic        mat;
        logic [4:0]  ecnt;
    } vec_t;

    vec_t        tbl[5];
    logic [15:0] fx_map;
    logic [15:0] m3;

    initial begin
        int lat;
        int k;
        logic [15:0] fm, ex;

        // fxyzw: s = 1 at vectors 0,3,4,8,12,13.
        fx_map = 16'd0;
        foreach (fx_map[i]) fx_map[i] = (i == 0 || i == 3 || i == 4 || i == 8 || i == 12 || i == 13);

        tbl[0] = '{fx_map,   16'h3119, 16'h3119, 1'b1, 5'd0};
        tbl[1] = '{fx_map,   16'h3118, 16'h3119, 1'b0, ERRCNT_ON ? 5'd1 : 5'd0};
        tbl[2] = '{16'h0000, 16'hFFFF, 16'h0000, 1'b0, ERRCNT_ON ? 5'd16 : 5'd0};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 5'd0};
        tbl[4] = '{16'h8001, 16'h0000, 16'h8001, 1'b0, ERRCNT_ON ? 5'd2 : 5'd0};

        reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
        expected1 = 16'd0; expected3 = 16'd0; func_map = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   int'(busy1), 0);
        chk("rst_done",   int'(done1), 0);
        chk("rst_result", int'(result1), 0);
        chk("rst_match",  int'(match1), 0);
        chk("rst_err",    int'(err1), 0);
        chk("rst_xywz",   int'({x1, y1, w1, z1}), 0);
        chk("rst_busy3",  int'(busy3), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            do_scan1($sformatf("tbl%0d", i), tbl[i].fmap, tbl[i].exp_in, -1,
                     tbl[i].res, tbl[i].mat, tbl[i].ecnt);
        end

        // Random function maps against the behavioural model: result is the map itself.
        for (int i = 0; i < 8; i++) begin
            fm = 16'($urandom);
            ex = (i % 2 == 0) ? fm : 16'($urandom);
            do_scan1($sformatf("rnd%0d", i), fm, ex, -1, fm, fm == ex,
                     ERRCNT_ON ? 5'($countones(fm ^ ex)) : 5'd0);
        end

        // start mid-scan at idx 7 must not restart nor relatch expected.
        do_scan1("midstart", fx_map, 16'h3119, 7, 16'h3119, 1'b1, 5'd0);

        // Reset at idx 9 of a following scan discards partial results.
        func_map = fx_map; expected1 = 16'h3119;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        k = 0;
        while ({x1, y1, w1, z1} != 4'd9 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("reach_idx9", int'(k < 100), 1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("midrst_busy",   int'(busy1), 0);
        chk("midrst_done",   int'(done1), 0);
        chk("midrst_result", int'(result1), 0);
        chk("midrst_match",  int'(match1), 0);
        chk("midrst_xywz",   int'({x1, y1, w1, z1}), 0);
        $display("reset at idx 9: busy=%b done=%b result=%h", busy1, done1, result1);

        // start held high across DONE: back-to-back scans.
        func_map = fx_map; expected1 = 16'h3119;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!done1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_first_lat", lat, 32);
        @(negedge clk);
        chk("b2b_done_drop", int'(done1), 0);
        chk("b2b_busy",      int'(busy1), 1);
        lat = 0;
        while (!done1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        start1 = 1'b0;
        chk("b2b_second_lat", lat, 32);
        chk("b2b_result", int'(result1), 16'h3119);
        chk("b2b_match",  int'(match1), 1);
        @(negedge clk);
        chk("b2b_done_hold", int'(done1), 1);
        $display("back-to-back: second scan cycles=%0d result=%h", lat, result1);

        // SETTLE_CYCLES=3 with registered s = x ^ z.
        for (int i = 0; i < 16; i++) m3[i] = 1'(((i >> 3) & 1) ^ (i & 1));
        expected3 = m3;
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        chk("s3_busy_rise", int'(busy3), 1);
        lat = 0;
        while (!done3 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("s3_latency", lat, 64);
        chk("s3_result",  int'(result3), int'(m3));
        chk("s3_match",   int'(match3), 1);
        chk("s3_err",     int'(err3), 0);
        chk("s3_busy_fall", int'(busy3), 0);
        $display("settle3: result=%h match=%b cycles=%0d", result3, match3, lat);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
